// File: rtl/btn_event_arbiter.sv
// Button event arbiter: latches single-cycle press pulses as per-button pending
// flags and serialises them round-robin into one registered valid/ready event slot.
// Optional feature: define BTN_EVT_DROP_CNT_EN to add the saturating drop_cnt output.
module btn_event_arbiter #(
  parameter int unsigned NBTN   = 4,
  parameter int unsigned ID_W   = 2,
  parameter int unsigned DROP_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] btn_pulse,
  output logic            evt_valid,
  output logic [ID_W-1:0] evt_id,
  input  logic            evt_ready
`ifdef BTN_EVT_DROP_CNT_EN
  ,
  output logic [DROP_W-1:0] drop_cnt
`endif
);

  localparam logic [0:0]      StEmpty = 1'b0;
  localparam logic [0:0]      StFull  = 1'b1;
  localparam logic [ID_W-1:0] LastId  = ID_W'(NBTN - 1);

  // Elaboration-time guard on the parameter ranges.
  if (NBTN < 2 || NBTN > 16 || NBTN > (1 << ID_W) || DROP_W < 1) begin : g_bad_params
    $error("btn_event_arbiter: invalid NBTN/ID_W/DROP_W");
  end

  logic [0:0]      state_q, state_d;
  logic [NBTN-1:0] pending_q, pending_d;
  logic [NBTN-1:0] grant_mask;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] evt_id_q, evt_id_d;
  logic [ID_W-1:0] grant_id;
  logic            slot_free;
  logic            any_pending;
  logic            grant;

  assign evt_valid   = (state_q == StFull);
  assign evt_id      = evt_id_q;
  assign slot_free   = !evt_valid || evt_ready;
  assign any_pending = |pending_q;
  assign grant       = slot_free && any_pending;

  // Round-robin search: first pending bit at or above rr_ptr, wrapping modulo NBTN.
  always_comb begin
    logic        hit;
    int unsigned idx;
    hit      = 1'b0;
    idx      = 0;
    grant_id = '0;
    for (int unsigned k = 0; k < NBTN; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NBTN) idx = idx - NBTN;
      if (!hit && pending_q[idx]) begin
        hit      = 1'b1;
        grant_id = ID_W'(idx);
      end
    end
  end

  // One-hot of the bit being granted this cycle (all zero when no grant).
  always_comb begin
    grant_mask = '0;
    for (int unsigned i = 0; i < NBTN; i++) begin
      grant_mask[i] = grant && (grant_id == ID_W'(i));
    end
  end

  // A pulse in the same cycle as its grant re-arms the flag.
  assign pending_d = (pending_q & ~grant_mask) | btn_pulse;

  // Slot FSM: load on grant, empty when free with nothing pending, hold otherwise.
  always_comb begin
    state_d  = state_q;
    evt_id_d = evt_id_q;
    rr_ptr_d = rr_ptr_q;
    if (slot_free) begin
      if (any_pending) begin
        state_d  = StFull;
        evt_id_d = grant_id;
        rr_ptr_d = (grant_id == LastId) ? '0 : grant_id + 1'b1;
      end else begin
        state_d = StEmpty;
      end
    end
  end

  // State registers with synchronous reset; pulses in the reset cycle are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StEmpty;
      pending_q <= '0;
      rr_ptr_q  <= '0;
      evt_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      evt_id_q  <= evt_id_d;
    end
  end

`ifdef BTN_EVT_DROP_CNT_EN
  localparam logic [DROP_W+4:0] DropMax = {5'b0, {DROP_W{1'b1}}};

  logic [NBTN-1:0]   drop_vec;
  logic [4:0]        drop_num;
  logic [DROP_W+4:0] drop_sum;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  // A drop is a pulse landing on an already-pending bit that is not granted now.
  assign drop_vec = btn_pulse & pending_q & ~grant_mask;

  // Count drops this cycle and add with saturation.
  always_comb begin
    drop_num = '0;
    for (int unsigned i = 0; i < NBTN; i++) begin
      drop_num = drop_num + 5'(drop_vec[i]);
    end
    drop_sum   = {5'b0, drop_cnt_q} + {{DROP_W{1'b0}}, drop_num};
    drop_cnt_d = (drop_sum > DropMax) ? '1 : drop_sum[DROP_W-1:0];
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule
